// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Multi-channel programmable clock-enable generator. Each of N_CH channels
//   derives a single-cycle TICK enable from CLK every P enabled cycles, plus
//   an optional divided square wave CLK_OUT of period 2P. Divisors are written
//   through a shared CFG bus into a per-channel shadow register. The shadow
//   value takes effect only at the channel's next terminal count or on SYNC,
//   so no period is ever shortened or stretched.
//
// Ports
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   EN       per-channel run enable
//   SYNC     synchronous restart of all channels (applies pending divisors)
//   CFG_WE   divisor write strobe
//   CFG_CH   channel index for write (indices >= N_CH are ignored)
//   CFG_DIV  new divisor; 0 and 1 both mean "tick every enabled cycle"
//   TICK     registered one-cycle enable pulse per channel
//   CLK_OUT  registered divided square wave per channel
//   PENDING  shadow divisor written but not yet applied
//
// Build option
//   CLKDIV_SQUARE_EN: when defined, CLK_OUT toggle flops are built.
//   When undefined, CLK_OUT is tied to 0 and no toggle flops exist.
//
// Parameter CH_W defaults to max(1,$clog2(N_CH)); it may be widened so that
// out-of-range channel indices can be presented on CFG_CH.

module clk_div_bank #(
   parameter int N_CH    = 4,
   parameter int DIV_W   = 16,
   parameter int RST_DIV = 2,
   parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_CH-1:0]   EN,
   input  logic              SYNC,
   input  logic              CFG_WE,
   input  logic [CH_W-1:0]   CFG_CH,
   input  logic [DIV_W-1:0]  CFG_DIV,
   output logic [N_CH-1:0]   TICK,
   output logic [N_CH-1:0]   CLK_OUT,
   output logic [N_CH-1:0]   PENDING
);

   localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);
   localparam logic [DIV_W-1:0] RST_CNT_V = DIV_W'(RST_DIV - 1);

   // Reload value for the down-counter: eff(x)-1, where eff(0)=1.
   function automatic logic [DIV_W-1:0] eff_m1(input logic [DIV_W-1:0] x);
      eff_m1 = (x == '0) ? '0 : (x - DIV_W'(1));
   endfunction

   logic [DIV_W-1:0] cnt_q     [N_CH];
   logic [DIV_W-1:0] cnt_d     [N_CH];
   logic [DIV_W-1:0] div_act_q [N_CH];
   logic [DIV_W-1:0] div_act_d [N_CH];
   logic [DIV_W-1:0] div_sh_q  [N_CH];
   logic [DIV_W-1:0] div_sh_d  [N_CH];
   logic [N_CH-1:0]  pending_q;
   logic [N_CH-1:0]  pending_d;
   logic [N_CH-1:0]  tick_q;
   logic [N_CH-1:0]  tick_d;
`ifdef CLKDIV_SQUARE_EN
   logic [N_CH-1:0]  clk_out_q;
   logic [N_CH-1:0]  clk_out_d;
`endif

   // One-hot decode of the config write; an out-of-range index matches nothing.
   logic [N_CH-1:0]  cfg_sel;

   always_comb begin
      cfg_sel = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (CFG_WE && (32'(CFG_CH) == i)) begin
            cfg_sel[i] = 1'b1;
         end
      end
   end

   // Next-state per channel. The apply step (SYNC or terminal count) reads the
   // pre-edge shadow; a same-cycle CFG write is layered on afterwards so it
   // lands in the shadow with PENDING set for the following terminal count.
   always_comb begin
      cnt_d     = cnt_q;
      div_act_d = div_act_q;
      div_sh_d  = div_sh_q;
      pending_d = pending_q;
      tick_d    = '0;
`ifdef CLKDIV_SQUARE_EN
      clk_out_d = clk_out_q;
`endif
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (SYNC) begin
            if (pending_q[i]) begin
               div_act_d[i] = div_sh_q[i];
               pending_d[i] = 1'b0;
            end
            cnt_d[i] = eff_m1(div_act_d[i]);
`ifdef CLKDIV_SQUARE_EN
            clk_out_d[i] = 1'b0;
`endif
         end else if (EN[i]) begin
            if (cnt_q[i] == '0) begin
               tick_d[i] = 1'b1;
`ifdef CLKDIV_SQUARE_EN
               clk_out_d[i] = ~clk_out_q[i];
`endif
               if (pending_q[i]) begin
                  div_act_d[i] = div_sh_q[i];
                  pending_d[i] = 1'b0;
               end
               cnt_d[i] = eff_m1(div_act_d[i]);
            end else begin
               cnt_d[i] = cnt_q[i] - DIV_W'(1);
            end
         end

         if (cfg_sel[i]) begin
            div_sh_d[i]  = CFG_DIV;
            pending_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i]     <= RST_CNT_V;
            div_act_q[i] <= RST_DIV_V;
            div_sh_q[i]  <= RST_DIV_V;
         end
         pending_q <= '0;
         tick_q    <= '0;
`ifdef CLKDIV_SQUARE_EN
         clk_out_q <= '0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
         div_sh_q  <= div_sh_d;
         pending_q <= pending_d;
         tick_q    <= tick_d;
`ifdef CLKDIV_SQUARE_EN
         clk_out_q <= clk_out_d;
`endif
      end
   end

   assign TICK    = tick_q;
   assign PENDING = pending_q;
`ifdef CLKDIV_SQUARE_EN
   assign CLK_OUT = clk_out_q;
`else
   assign CLK_OUT = '0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. A behavioural model tracks, per
// channel, how many enabled cycles have elapsed in the current period and
// which divisor is active/queued; expected outputs follow from that.

module tb_clk_div_bank;

   localparam int N_CH    = 4;
   localparam int DIV_W   = 16;
   localparam int RST_DIV = 2;
   localparam int CH_W    = 3;

   logic              CLK = 1'b0;
   logic              RST;
   logic [N_CH-1:0]   EN;
   logic              SYNC;
   logic              CFG_WE;
   logic [CH_W-1:0]   CFG_CH;
   logic [DIV_W-1:0]  CFG_DIV;
   logic [N_CH-1:0]   TICK;
   logic [N_CH-1:0]   CLK_OUT;
   logic [N_CH-1:0]   PENDING;

   clk_div_bank #(
      .N_CH    (N_CH),
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV),
      .CH_W    (CH_W)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .SYNC    (SYNC),
      .CFG_WE  (CFG_WE),
      .CFG_CH  (CFG_CH),
      .CFG_DIV (CFG_DIV),
      .TICK    (TICK),
      .CLK_OUT (CLK_OUT),
      .PENDING (PENDING)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_act     [N_CH];
   int m_sh      [N_CH];
   int m_elapsed [N_CH];
   bit m_pend    [N_CH];
   bit m_tick    [N_CH];
   bit m_sq      [N_CH];

   function automatic int eff(int p);
      return (p == 0) ? 1 : p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one rising edge to the model using the currently driven inputs.
   task automatic model_edge();
      for (int ch = 0; ch < N_CH; ch++) begin
         if (RST) begin
            m_act[ch] = RST_DIV; m_sh[ch] = RST_DIV; m_pend[ch] = 0;
            m_elapsed[ch] = 0; m_tick[ch] = 0; m_sq[ch] = 0;
         end else begin
            m_tick[ch] = 0;
            if (SYNC) begin
               if (m_pend[ch]) begin m_act[ch] = m_sh[ch]; m_pend[ch] = 0; end
               m_elapsed[ch] = 0;
               m_sq[ch] = 0;
            end else if (EN[ch]) begin
               m_elapsed[ch]++;
               if (m_elapsed[ch] >= eff(m_act[ch])) begin
                  m_tick[ch] = 1;
                  m_sq[ch] = ~m_sq[ch];
                  m_elapsed[ch] = 0;
                  if (m_pend[ch]) begin m_act[ch] = m_sh[ch]; m_pend[ch] = 0; end
               end
            end
            if (CFG_WE && int'(CFG_CH) == ch) begin
               m_sh[ch] = int'(CFG_DIV);
               m_pend[ch] = 1;
            end
         end
      end
   endtask

   task automatic step();
      logic [N_CH-1:0] et, es, ep;
      @(posedge CLK);
      model_edge();
      #1;
      for (int ch = 0; ch < N_CH; ch++) begin
         et[ch] = m_tick[ch];
         ep[ch] = m_pend[ch];
`ifdef CLKDIV_SQUARE_EN
         es[ch] = m_sq[ch];
`else
         es[ch] = 1'b0;
`endif
      end
      check("tick", 32'(TICK), 32'(et));
      check("clk_out", 32'(CLK_OUT), 32'(es));
      check("pending", 32'(PENDING), 32'(ep));
   endtask

   task automatic write_cfg(input int ch, input int div);
      CFG_WE = 1'b1; CFG_CH = CH_W'(ch); CFG_DIV = DIV_W'(div);
      step();
      CFG_WE = 1'b0;
   endtask

   task automatic do_sync();
      SYNC = 1'b1;
      step();
      SYNC = 1'b0;
   endtask

   logic [N_CH-1:0] sq_all;
   int tick_times[$];
   int cyc;

   initial begin
      RST = 1'b1; EN = '0; SYNC = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_DIV = '0;
`ifdef CLKDIV_SQUARE_EN
      sq_all = '1;
`else
      sq_all = '0;
`endif

      // Reset and first ticks
      repeat (3) begin
         step();
         check("rst_tick", 32'(TICK), 32'h0);
         check("rst_clk_out", 32'(CLK_OUT), 32'h0);
      end
      RST = 1'b0; EN = '1;
      step();
      check("first_c1", 32'(TICK), 32'h0);
      step();
      check("first_c2", 32'(TICK), 32'hF);
      check("first_sq", 32'(CLK_OUT), 32'(sq_all));
      check("first_pend", 32'(PENDING), 32'h0);

      // Mid-period divisor write on ch1: ticks settle to a period of 5
      step();
      write_cfg(1, 5);
      check("wr_pend1", 32'(PENDING[1]), 32'h1);
      tick_times.delete();
      for (int c = 0; c < 20; c++) begin
         step();
         if (TICK[1]) tick_times.push_back(c);
      end
      check("wr_nticks", 32'(tick_times.size() >= 3), 32'h1);
      if (tick_times.size() >= 3)
         check("wr_period", 32'(tick_times[$] - tick_times[$-1]), 32'd5);
      check("wr_pend_clr", 32'(PENDING[1]), 32'h0);

      // Edge divisors 0 and 1 on ch0: tick every cycle
      for (int d = 0; d < 2; d++) begin
         write_cfg(0, d);
         cyc = 0;
         while (PENDING[0] && cyc < 20) begin step(); cyc++; end
         check("edge_applied", 32'(PENDING[0]), 32'h0);
         repeat (4) begin
            step();
            check("edge_tick", 32'(TICK[0]), 32'h1);
         end
      end

      // EN gating on ch3 with P=4
      write_cfg(3, 4);
      do_sync();
      repeat (2) step();
      EN[3] = 1'b0;
      repeat (7) begin
         step();
         check("gate_tick", 32'(TICK[3]), 32'h0);
      end
      EN[3] = 1'b1;
      step();
      check("gate_resume1", 32'(TICK[3]), 32'h0);
      step();
      check("gate_resume2", 32'(TICK[3]), 32'h1);

      // SYNC with pending write and simultaneous CFG_WE on ch0
      write_cfg(0, 3);
      SYNC = 1'b1; CFG_WE = 1'b1; CFG_CH = 3'd0; CFG_DIV = 16'd7;
      step();
      SYNC = 1'b0; CFG_WE = 1'b0;
      check("sync_pend0", 32'(PENDING[0]), 32'h1);
      check("sync_sq", 32'(CLK_OUT), 32'h0);
      step(); step();
      check("sync_c2", 32'(TICK[0]), 32'h0);
      step();
      check("sync_c3", 32'(TICK[0]), 32'h1);

      // Out-of-range channel index
      do_sync();
      check("inv_pre", 32'(PENDING), 32'h0);
      write_cfg(5, 9);
      check("inv_pend", 32'(PENDING), 32'h0);
      write_cfg(7, 1);
      check("inv_pend7", 32'(PENDING), 32'h0);
      repeat (10) step();

      // Maximum divisor on ch2
      write_cfg(2, 16'hFFFF);
      do_sync();
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!TICK[2] && cyc < 70000);
      check("max_period", 32'(cyc), 32'd65535);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         RST    = ($urandom_range(0, 299) == 0);
         SYNC   = ($urandom_range(0, 39) == 0);
         EN     = N_CH'($urandom);
         CFG_WE = ($urandom_range(0, 3) == 0);
         CFG_CH = CH_W'($urandom_range(0, 7));
         CFG_DIV = DIV_W'($urandom_range(0, 6));
         step();
      end
      RST = 1'b0; SYNC = 1'b0; CFG_WE = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
